demux_chan_counter: RTL and testbench

DEMUX_CHAN_COUNTER -- requirements
Module: demux_chan_counter

---
 rtl/demux_chan_counter_if.sv | 11 +
 rtl/demux_chan_counter.sv | 102 ++++++++++
 tb/tb_demux_chan_counter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_chan_counter_if.sv
// Read-port bundle for demux_chan_counter: request/select in, acknowledge/data out.
// The master side issues reads and the slave side (the counter block) answers them.
interface demux_chan_counter_if;
  logic       rd_req;
  logic [2:0] rd_sel;
  logic       rd_ack;
  logic [7:0] rd_data;

  modport master (output rd_req, output rd_sel, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_sel, output rd_ack, output rd_data);
endinterface

// File: rtl/demux_chan_counter.sv
// Per-channel rising-edge counters behind a DEMUX1_8 output bus, with a 3-state read port.
// Optional macro CHAN_RD_CLEAR_EN makes reads destructive (the selected counter and its OVF bit clear on capture).
module demux_chan_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ch_in,
  input  logic       clr,
  demux_chan_counter_if.slave rd,
  output logic [7:0] active,
  output logic [7:0] ovf
);

  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

  state_t     state;
  logic [2:0] sel_q;
  logic [7:0] ch_q;
  logic [7:0] edge_vec;
  logic [7:0] rd_clr;
  logic [7:0] cnt [8];

  assign edge_vec = ch_in & ~ch_q;

`ifdef CHAN_RD_CLEAR_EN
  always_comb begin
    rd_clr = '0;
    if (state == LOAD) rd_clr[sel_q] = 1'b1;
  end
`else
  assign rd_clr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      active <= '0;
    end else begin
      ch_q <= ch_in;
      if (clr)
        active <= '0;
      else if (|edge_vec)
        active <= edge_vec;
    end
  end

  // A read-clear that coincides with an edge restarts the count at 1, not 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (clr) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (rd_clr[i]) begin
          cnt[i] <= {7'd0, edge_vec[i]};
          ovf[i] <= 1'b0;
        end else if (edge_vec[i]) begin
          if (cnt[i] == 8'hFF)
            ovf[i] <= 1'b1;
          else
            cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  // LOAD captures the pre-edge counter value, so a coincident CLR or edge is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel_q      <= '0;
      rd.rd_data <= '0;
      rd.rd_ack  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd.rd_ack <= 1'b0;
          if (rd.rd_req) begin
            sel_q <= rd.rd_sel;
            state <= LOAD;
          end
        end
        LOAD: begin
          rd.rd_data <= cnt[sel_q];
          rd.rd_ack  <= 1'b1;
          state      <= ACK;
        end
        ACK: begin
          rd.rd_ack <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          rd.rd_ack <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_chan_counter.sv
// Self-checking bench for demux_chan_counter: table of pulse/read vectors plus hand-written corner sequences.
// Read data is checked through a scoreboard queue drained by a monitor on every RD_ACK.
module tb_demux_chan_counter;

  logic       clk;
  logic       rst_n;
  logic [7:0] ch_in;
  logic       clr;
  logic [7:0] active;
  logic [7:0] ovf;

  demux_chan_counter_if rd_if ();

  demux_chan_counter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ch_in  (ch_in),
    .clr    (clr),
    .rd     (rd_if),
    .active (active),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int ack_count = 0;
  int ack_cyc [$];
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] mask;
    int         pulses;
    logic [2:0] sel;
    logic [7:0] exp_data;
    logic [7:0] exp_active;
  } vec_t;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every acknowledged read pops one expected value from the scoreboard.
  always @(negedge clk) begin
    if (rd_if.rd_ack === 1'b1) begin
      ack_count++;
      ack_cyc.push_back(cyc);
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_ack: got rd_ack=1 rd_data=%0d, required no ack", rd_if.rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_if.rd_data !== e) begin
          mismatched++;
          $display("[TB] FAIL rd_data: got %0d, required %0d", rd_if.rd_data, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      ch_in = mask;
      tick();
      ch_in = 8'h00;
      tick();
    end
  endtask

  // Issue one read from IDLE, verify the 2-cycle ACK latency, and return to IDLE.
  task automatic read_chan(input logic [2:0] sel, input logic [7:0] exp);
    exp_q.push_back(exp);
    rd_if.rd_req = 1'b1;
    rd_if.rd_sel = sel;
    tick();
    rd_if.rd_req = 1'b0;
    rd_if.rd_sel = 3'($urandom_range(0, 7));
    check_output("ack_early", 32'(rd_if.rd_ack), 32'd0);
    tick();
    check_output("ack_latency", 32'(rd_if.rd_ack), 32'd1);
    tick();
  endtask

  vec_t vecs [8];
  int acks_before;

  initial begin
    vecs[0] = '{8'h04, 5, 3'd2, 8'd5, 8'h04};
    vecs[1] = '{8'h04, 5, 3'd3, 8'd0, 8'h04};
    vecs[2] = '{8'h81, 3, 3'd0, 8'd3, 8'h81};
    vecs[3] = '{8'h81, 3, 3'd7, 8'd3, 8'h81};
    vecs[4] = '{8'hFF, 2, 3'd5, 8'd2, 8'hFF};
    vecs[5] = '{8'h0A, 7, 3'd1, 8'd7, 8'h0A};
    vecs[6] = '{8'h0A, 1, 3'd6, 8'd0, 8'h0A};
    vecs[7] = '{8'h40, 0, 3'd6, 8'd0, 8'h00};

    rst_n = 1'b0;
    ch_in = 8'h00;
    clr = 1'b0;
    rd_if.rd_req = 1'b0;
    rd_if.rd_sel = 3'd0;
    tick(2);
    check_output("reset_ack", 32'(rd_if.rd_ack), 32'd0);
    check_output("reset_data", 32'(rd_if.rd_data), 32'd0);
    check_output("reset_active", 32'(active), 32'd0);
    check_output("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      do_clear();
      apply_stimulus(vecs[v].mask, vecs[v].pulses);
      read_chan(vecs[v].sel, vecs[v].exp_data);
      check_output($sformatf("vec%0d_active", v), 32'(active), 32'(vecs[v].exp_active));
      check_output($sformatf("vec%0d_ovf", v), 32'(ovf), 32'd0);
    end

    // Saturation at 255 with sticky OVF, then CLR.
    do_clear();
    apply_stimulus(8'h80, 260);
    read_chan(3'd7, 8'd255);
    check_output("sat_ovf", 32'(ovf), 32'h80);
    check_output("sat_active", 32'(active), 32'h80);
    do_clear();
    read_chan(3'd7, 8'd0);
    check_output("clr_ovf", 32'(ovf), 32'd0);
    check_output("clr_active", 32'(active), 32'd0);

    // CLR beats a coincident edge on channel 0.
    ch_in = 8'h01;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ch_in = 8'h00;
    check_output("clr_edge_active", 32'(active), 32'd0);
    tick();
    read_chan(3'd0, 8'd0);
    apply_stimulus(8'h01, 1);
    read_chan(3'd0, 8'd1);
    check_output("post_clr_active", 32'(active), 32'h01);

    // RD_REQ held high for 9 cycles gives three reads, 3 cycles apart.
    do_clear();
    apply_stimulus(8'h08, 2);
    ack_cyc.delete();
    acks_before = ack_count;
    for (int i = 0; i < 3; i++) exp_q.push_back(8'd2);
    rd_if.rd_req = 1'b1;
    rd_if.rd_sel = 3'd3;
    tick(9);
    rd_if.rd_req = 1'b0;
    tick(3);
    check_output("held_ack_count", 32'(ack_count - acks_before), 32'd3);
    if (ack_cyc.size() == 3) begin
      check_output("held_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
      check_output("held_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);
    end

    // RD_SEL/RD_REQ changes outside IDLE are ignored.
    do_clear();
    apply_stimulus(8'h04, 2);
    apply_stimulus(8'h01, 9);
    exp_q.push_back(8'd2);
    rd_if.rd_req = 1'b1;
    rd_if.rd_sel = 3'd2;
    tick();
    rd_if.rd_sel = 3'd0;
    tick();
    rd_if.rd_req = 1'b0;
    check_output("selchg_ack", 32'(rd_if.rd_ack), 32'd1);
    tick(2);
    check_output("selchg_no_extra", 32'(rd_if.rd_ack), 32'd0);

    // CLR during LOAD returns the pre-CLR count and does not abort the read.
    do_clear();
    apply_stimulus(8'h20, 6);
    exp_q.push_back(8'd6);
    rd_if.rd_req = 1'b1;
    rd_if.rd_sel = 3'd5;
    tick();
    rd_if.rd_req = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_output("clr_load_ack", 32'(rd_if.rd_ack), 32'd1);
    tick();
    read_chan(3'd5, 8'd0);

`ifdef CHAN_RD_CLEAR_EN
    do_clear();
    apply_stimulus(8'h02, 4);
    read_chan(3'd1, 8'd4);
    read_chan(3'd1, 8'd0);
    apply_stimulus(8'h02, 4);
    exp_q.push_back(8'd4);
    rd_if.rd_req = 1'b1;
    rd_if.rd_sel = 3'd1;
    tick();
    rd_if.rd_req = 1'b0;
    ch_in = 8'h02;
    tick();
    ch_in = 8'h00;
    check_output("rdclr_edge_ack", 32'(rd_if.rd_ack), 32'd1);
    tick();
    read_chan(3'd1, 8'd1);
`else
    do_clear();
    apply_stimulus(8'h02, 4);
    read_chan(3'd1, 8'd4);
    read_chan(3'd1, 8'd4);
`endif

    // Channels already high at reset release count exactly one edge.
    ch_in = 8'hFF;
    rst_n = 1'b0;
    tick(2);
    check_output("rst_hi_active", 32'(active), 32'd0);
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) read_chan(3'(c), 8'd1);
    check_output("rst_hi_active_after", 32'(active), 32'hFF);

    // Reset during LOAD drops the read.
    acks_before = ack_count;
    rd_if.rd_req = 1'b1;
    rd_if.rd_sel = 3'd0;
    tick();
    rd_if.rd_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrd_ack", 32'(rd_if.rd_ack), 32'd0);
    check_output("midrd_data", 32'(rd_if.rd_data), 32'd0);
    check_output("midrd_active", 32'(active), 32'd0);
    check_output("midrd_ovf", 32'(ovf), 32'd0);
    tick(3);
    check_output("midrd_no_ack", 32'(ack_count - acks_before), 32'd0);
    ch_in = 8'h00;
    rst_n = 1'b1;
    tick(2);

    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
